// File: rtl/tick_debouncer.sv
// rtl/tick_debouncer.sv - tick-paced pushbutton debouncer with press/release pulses
module tick_debouncer #(
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CNT_W = $clog2(STABLE_TICKS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (sync2_q) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        // A revert outranks a same-cycle tick: the candidate level was not stable.
        if (!sync2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      IDLE_HI: begin
        if (!sync2_q) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (sync2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: tb/tb_tick_debouncer.sv
// tb/tb_tick_debouncer.sv - randomized scoreboard bench for tick_debouncer (STABLE_TICKS=4 and 1)
module tb_tick_debouncer;

  localparam int NCYC = 6000;

  logic clk = 1'b0;
  logic reset_n;
  logic tick;
  logic btn_raw;
  logic lvl4, pr4, rl4;
  logic lvl1, pr1, rl1;

  always #5 clk = ~clk;

  tick_debouncer #(.STABLE_TICKS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .btn_raw(btn_raw),
    .btn_level(lvl4), .press_pulse(pr4), .release_pulse(rl4)
  );

  tick_debouncer #(.STABLE_TICKS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .btn_raw(btn_raw),
    .btn_level(lvl1), .press_pulse(pr1), .release_pulse(rl1)
  );

  logic [5:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  bit stim_done = 1'b0;

  // Reference model: input histories indexed by clock edge.
  bit raw_hist [0:NCYC-1];
  bit tick_hist[0:NCYC-1];
  int first_live = 0;
  int need  [2] = '{4, 1};
  bit level [2];
  bit active[2];
  int start [2];
  bit press [2];
  bit rel   [2];

  function automatic bit synced_at(int k);
    // value the debouncer sees before edge k: raw captured two edges earlier, if since reset
    if (k - 2 >= first_live) return raw_hist[k-2];
    return 1'b0;
  endfunction

  function automatic int ticks_between(int a, int b);
    int s = 0;
    for (int j = a + 1; j <= b; j++) s += int'(tick_hist[j]);
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      level[i] = 0; active[i] = 0; press[i] = 0; rel[i] = 0;
    end
  endtask

  task automatic model_step(int k, bit rst_n_at_edge);
    bit s;
    if (!rst_n_at_edge) begin
      model_clear();
      first_live = k + 1;
      return;
    end
    s = synced_at(k);
    for (int i = 0; i < 2; i++) begin
      press[i] = 0;
      rel[i]   = 0;
      if (s == level[i]) begin
        active[i] = 0;
      end else if (!active[i]) begin
        active[i] = 1;
        start[i]  = k;
      end else if (tick_hist[k] && ticks_between(start[i], k) == need[i]) begin
        level[i]  = ~level[i];
        press[i]  = level[i];
        rel[i]    = ~level[i];
        active[i] = 0;
      end
    end
  endtask

  initial begin : stim
    int seg_left, tmode, tphase;
    bit seg_val, rst_n_at_edge;
    reset_n = 1'b0;
    btn_raw = 1'b1;
    tick    = 1'b0;
    seg_val = 1'b1;
    seg_left = 40;
    tmode = 0;
    tphase = 0;
    model_clear();
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      raw_hist[k]  = btn_raw;
      tick_hist[k] = tick;
      rst_n_at_edge = reset_n;
      model_step(k, rst_n_at_edge);

      if (k % 250 == 249) tmode = $urandom_range(0, 2);
      tphase = (tphase + 1) % 3;
      case (tmode)
        0:       tick = (tphase == 0);
        1:       tick = ($urandom_range(0, 3) == 0);
        default: tick = 1'b1;
      endcase

      if (seg_left == 0) begin
        seg_val = ($urandom_range(0, 4) != 0) ? ~seg_val : seg_val;
        seg_left = ($urandom_range(0, 9) < 4) ? $urandom_range(1, 3) : $urandom_range(8, 40);
      end
      seg_left--;
      btn_raw = seg_val;

      if (k < 9) reset_n = 1'b0;
      else if (!reset_n) reset_n = ($urandom_range(0, 1) == 0);
      else reset_n = ($urandom_range(0, 299) != 0);
      if (!reset_n) model_clear();

      exp_q.push_back({level[1], press[1], rel[1], level[0], press[0], rel[0]});
    end
    stim_done = 1'b1;
    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : monitor
    int cyc = 0;
    logic [5:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      got_v = {lvl1, pr1, rl1, lvl4, pr4, rl4};
      if (exp_q.size() == 0) begin
        if (!stim_done) begin
          compared++;
          mismatched++;
          $display("FAIL queue_empty cycle %0d: got %b, no expectation", cyc, got_v);
        end
      end else begin
        exp_v = exp_q.pop_front();
        compared++;
        if (got_v !== exp_v) begin
          mismatched++;
          $display("FAIL outputs cycle %0d {lvl1,pr1,rl1,lvl4,pr4,rl4}: got %b required %b",
                   cyc, got_v, exp_v);
        end
      end
      cyc++;
    end
  end

endmodule
